key_input_ctrl: RTL and testbench

KEY_INPUT_CTRL -- requirements
Module: key_input_ctrl

---
 rtl/key_input_ctrl.sv | 160 ++++++++++++++++
 tb/tb_key_input_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_input_ctrl
//  Description : PS/2 set-2 scan byte parser with per-key held state and
//                delayed auto-repeat (DAS) for the left/right/down actions.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_input_ctrl #(
    parameter int DAS_DELAY = 16_000_000,
    parameter int DAS_RATE  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       key_left,
    output logic       key_right,
    output logic       key_down,
    output logic       key_rotate,
    output logic       key_drop,
    output logic [4:0] held
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_EXT     = 2'd1;
    localparam logic [1:0] c_ST_BRK     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    localparam logic [7:0] c_CODE_EXT    = 8'hE0;
    localparam logic [7:0] c_CODE_BRK    = 8'hF0;
    localparam logic [7:0] c_CODE_LEFT   = 8'h6B;
    localparam logic [7:0] c_CODE_RIGHT  = 8'h74;
    localparam logic [7:0] c_CODE_DOWN   = 8'h72;
    localparam logic [7:0] c_CODE_ROTATE = 8'h75;
    localparam logic [7:0] c_CODE_DROP   = 8'h29;

    localparam logic [31:0] c_DELAY  = 32'(DAS_DELAY);
    localparam logic [31:0] c_RELOAD = 32'(DAS_DELAY - DAS_RATE);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [4:0] w_key;
    logic [4:0] w_make;
    logic [4:0] w_break;
    logic [4:0] w_press;
    logic [4:0] w_rpt;
    logic [4:0] r_held;
    logic [4:0] r_pulse;

    // ------------------------------------------------------------------
    // Parser state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Parser next-state: E0 always restarts an extended sequence, repeated
    // F0 prefixes are absorbed, anything else terminates the sequence.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (scan_valid) begin
            if (scan_code == c_CODE_EXT) begin
                w_state_nxt = c_ST_EXT;
            end else if (scan_code == c_CODE_BRK) begin
                case (r_state)
                    c_ST_IDLE: w_state_nxt = c_ST_BRK;
                    c_ST_EXT:  w_state_nxt = c_ST_EXT_BRK;
                    default:   w_state_nxt = r_state;
                endcase
            end else begin
                w_state_nxt = c_ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Parser outputs: resolve a final byte into make/break key events.
    // Bit order {drop, rotate, down, right, left}.
    // ------------------------------------------------------------------
    always_comb begin
        w_key   = 5'b00000;
        w_make  = 5'b00000;
        w_break = 5'b00000;
        if (scan_valid && (scan_code != c_CODE_EXT) && (scan_code != c_CODE_BRK)) begin
            if ((r_state == c_ST_EXT) || (r_state == c_ST_EXT_BRK)) begin
                case (scan_code)
                    c_CODE_LEFT:   w_key[0] = 1'b1;
                    c_CODE_RIGHT:  w_key[1] = 1'b1;
                    c_CODE_DOWN:   w_key[2] = 1'b1;
                    c_CODE_ROTATE: w_key[3] = 1'b1;
                    default:       w_key    = 5'b00000;
                endcase
            end else if (scan_code == c_CODE_DROP) begin
                w_key[4] = 1'b1;
            end
            if ((r_state == c_ST_BRK) || (r_state == c_ST_EXT_BRK)) begin
                w_break = w_key;
            end else begin
                w_make = w_key;
            end
        end
    end

    // Typematic makes of an already-held key are not new presses.
    assign w_press = w_make & ~r_held;

    // ------------------------------------------------------------------
    // Auto-repeat counters for the movement keys
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_rpt
        logic [31:0] r_cnt;
        logic        w_fire;

        // A break on the firing cycle suppresses the repeat pulse.
        assign w_fire   = r_held[i] && !w_break[i] && ((r_cnt + 32'd1) == c_DELAY);
        assign w_rpt[i] = w_fire;

        always_ff @(posedge clk) begin
            if (rst || w_break[i] || w_press[i]) begin
                r_cnt <= 32'd0;
            end else if (r_held[i]) begin
                if (w_fire) begin
                    r_cnt <= c_RELOAD;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

    assign w_rpt[4:3] = 2'b00;

    // ------------------------------------------------------------------
    // Held state and registered action pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held  <= 5'b00000;
            r_pulse <= 5'b00000;
        end else begin
            r_held  <= (r_held | w_make) & ~w_break;
            r_pulse <= w_press | w_rpt;
        end
    end

    assign key_left   = r_pulse[0];
    assign key_right  = r_pulse[1];
    assign key_down   = r_pulse[2];
    assign key_rotate = r_pulse[3];
    assign key_drop   = r_pulse[4];
    assign held       = r_held;

endmodule
`default_nettype wire

// File: tb/tb_key_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_input_ctrl
//  Description : Directed self-checking bench for key_input_ctrl
//                (DAS_DELAY = 10, DAS_RATE = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_input_ctrl;

    localparam int c_DD = 10;
    localparam int c_DR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       key_left;
    logic       key_right;
    logic       key_down;
    logic       key_rotate;
    logic       key_drop;
    logic [4:0] held;
    logic [4:0] pulses;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign pulses = {key_drop, key_rotate, key_down, key_right, key_left};

    key_input_ctrl #(
        .DAS_DELAY (c_DD),
        .DAS_RATE  (c_DR)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_down   (key_down),
        .key_rotate (key_rotate),
        .key_drop   (key_drop),
        .held       (held)
    );

    // Strobe one byte; returns at the sample point of the following cycle.
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    // Pulse expected k cycles after the left-key strobe for a key pressed at t0.
    function automatic logic exp_train(input int k, input int t0);
        return (k == t0 + 1) || ((k >= t0 + c_DD + 1) && (((k - t0 - c_DD - 1) % c_DR) == 0));
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (pulses !== 5'b00000) begin bad++; $display("FAIL reset_pulses: got %b want 00000", pulses); end
        total++; if (held !== 5'b00000) begin bad++; $display("FAIL reset_held: got %b want 00000", held); end
        rst = 1'b0;
        @(negedge clk);
        total++; if ({pulses, held} !== 10'd0) begin bad++; $display("FAIL reset_release: got %b want 0", {pulses, held}); end
    endtask

    task automatic test_rotate();
        send(8'hE0);
        total++; if (pulses !== 5'b00000) begin bad++; $display("FAIL rot_prefix: got %b want 00000", pulses); end
        send(8'h75);
        total++; if (pulses !== 5'b01000) begin bad++; $display("FAIL rot_pulse: got %b want 01000", pulses); end
        total++; if (held !== 5'b00100 << 1) begin bad++; $display("FAIL rot_held: got %b want 01000", held); end
        for (int k = 2; k <= 101; k++) begin
            @(negedge clk);
            total++; if (pulses !== 5'b00000) begin bad++; $display("FAIL rot_norepeat k=%0d: got %b want 00000", k, pulses); end
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        total++; if ({pulses, held} !== 10'd0) begin bad++; $display("FAIL rot_release: got %b want 0", {pulses, held}); end
    endtask

    task automatic test_left_repeat();
        logic exp;
        send(8'hE0);
        send(8'h6B);
        for (int k = 1; k <= 50; k++) begin
            exp = (k == 1) || (k == 11) || (k == 15) || (k == 19) || (k == 23) || (k == 27);
            total++; if (key_left !== exp) begin bad++; $display("FAIL left_train k=%0d: got %b want %b", k, key_left, exp); end
            total++; if (pulses[4:1] !== 4'b0000) begin bad++; $display("FAIL left_others k=%0d: got %b want 0000", k, pulses[4:1]); end
            total++; if (held !== ((k <= 30) ? 5'b00001 : 5'b00000)) begin bad++; $display("FAIL left_held k=%0d: got %b", k, held); end
            scan_valid = (k >= 28) && (k <= 30);
            scan_code  = (k == 28) ? 8'hE0 : (k == 29) ? 8'hF0 : (k == 30) ? 8'h6B : 8'h00;
            @(negedge clk);
        end
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic test_typematic_drop();
        send(8'h29);
        total++; if (pulses !== 5'b10000) begin bad++; $display("FAIL drop_pulse: got %b want 10000", pulses); end
        total++; if (held !== 5'b10000) begin bad++; $display("FAIL drop_held: got %b want 10000", held); end
        for (int k = 2; k <= 21; k++) begin
            scan_valid = (k % 5) == 1;
            scan_code  = ((k % 5) == 1) ? 8'h29 : 8'h00;
            @(negedge clk);
            total++; if (pulses !== 5'b00000) begin bad++; $display("FAIL drop_typematic k=%0d: got %b want 00000", k, pulses); end
            total++; if (held !== 5'b10000) begin bad++; $display("FAIL drop_hold k=%0d: got %b want 10000", k, held); end
        end
        scan_valid = 1'b0;
        send(8'hF0);
        total++; if (held !== 5'b10000) begin bad++; $display("FAIL drop_before_brk: got %b want 10000", held); end
        send(8'h29);
        total++; if (held !== 5'b00000) begin bad++; $display("FAIL drop_released: got %b want 00000", held); end
        for (int k = 0; k < 15; k++) begin
            total++; if (pulses !== 5'b00000) begin bad++; $display("FAIL drop_after k=%0d: got %b want 00000", k, pulses); end
            @(negedge clk);
        end
    endtask

    task automatic test_multi_key();
        logic [4:0] exp;
        send(8'hE0);
        send(8'h6B);
        for (int k = 1; k <= 36; k++) begin
            exp = {2'b00, exp_train(k, 2), exp_train(k, 4), exp_train(k, 0)};
            total++; if (pulses !== exp) begin bad++; $display("FAIL multi_pulses k=%0d: got %b want %b", k, pulses, exp); end
            scan_valid = (k >= 1) && (k <= 4);
            scan_code  = (k == 1 || k == 3) ? 8'hE0 : (k == 2) ? 8'h72 : (k == 4) ? 8'h74 : 8'h00;
            @(negedge clk);
        end
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        total++; if (held !== 5'b00111) begin bad++; $display("FAIL multi_held: got %b want 00111", held); end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++; if ({pulses, held} !== 10'd0) begin bad++; $display("FAIL multi_in_reset: got %b want 0", {pulses, held}); end
        end
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            total++; if ({pulses, held} !== 10'd0) begin bad++; $display("FAIL multi_after_reset k=%0d: got %b want 0", k, {pulses, held}); end
        end
    endtask

    task automatic test_ignored_bytes();
        logic [7:0] seq [5];
        seq = '{8'h6B, 8'h1C, 8'hF0, 8'hF0, 8'h74};
        send(8'h29);
        total++; if (pulses !== 5'b10000) begin bad++; $display("FAIL ign_drop_pulse: got %b want 10000", pulses); end
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            total++; if (pulses !== 5'b00000) begin bad++; $display("FAIL ign_pulse i=%0d: got %b want 00000", i, pulses); end
            total++; if (held !== 5'b10000) begin bad++; $display("FAIL ign_held i=%0d: got %b want 10000", i, held); end
        end
        send(8'hF0);
        send(8'h29);
        total++; if ({pulses, held} !== 10'd0) begin bad++; $display("FAIL ign_release: got %b want 0", {pulses, held}); end
    endtask

    task automatic test_reset_mid_sequence();
        send(8'hE0);
        rst        = 1'b1;
        scan_valid = 1'b1;
        scan_code  = 8'h29;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        total++; if ({pulses, held} !== 10'd0) begin bad++; $display("FAIL mid_in_reset: got %b want 0", {pulses, held}); end
        @(negedge clk);
        rst = 1'b0;
        send(8'h6B);
        total++; if (key_left !== 1'b0) begin bad++; $display("FAIL mid_no_left: got %b want 0", key_left); end
        for (int k = 0; k < 15; k++) begin
            total++; if ({pulses, held} !== 10'd0) begin bad++; $display("FAIL mid_after k=%0d: got %b want 0", k, {pulses, held}); end
            @(negedge clk);
        end
        send(8'hE0);
        send(8'h6B);
        total++; if (pulses !== 5'b00001) begin bad++; $display("FAIL mid_new_make: got %b want 00001", pulses); end
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        total++; if (held !== 5'b00000) begin bad++; $display("FAIL mid_release: got %b want 00000", held); end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_left_repeat();
        test_typematic_drop();
        test_multi_key();
        test_ignored_bytes();
        test_reset_mid_sequence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
